// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready bus between the MEM-stage load/store unit (master)
// and the data memory (slave).
interface mem_access_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [31:0]           dmem_wdata;
  logic [3:0]            dmem_be;
  logic                  dmem_ready;
  logic [31:0]           dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: dmem handshake, store byte-enables, load formatting, stall.
// Optional MISALIGN_TRAP_EN adds misalign_out and traps misaligned H/W accesses.
module mem_access_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [2:0]            funct3_in,
  input  logic [ADDR_WIDTH-1:0] alu_result_in,
  input  logic [31:0]           write_data_in,
  input  logic                  RegWrite_in,
  input  logic                  MemtoReg_in,
  input  logic [4:0]            rd_in,
  output logic                  RegWrite_out,
  output logic                  MemtoReg_out,
  output logic [31:0]           read_data_out,
  output logic [ADDR_WIDTH-1:0] alu_result_out,
  output logic [4:0]            rd_out,
  output logic                  stall_out,
  output logic                  timeout_out,
`ifdef MISALIGN_TRAP_EN
  output logic                  misalign_out,
`endif
  mem_access_stage_if.master    dmem
);

  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            be;
    logic [1:0]            sz;
    logic                  uns;
    logic                  we;
  } acc_t;

  logic [1:0]    state;
  logic          req_q, to_q, mis_q;
  logic [31:0]   data_q;
  logic [CW-1:0] wait_cnt;
  acc_t          acc, acc_nxt;

  logic          mem_op, misaligned, stall_core, in_done, timeout_hit;
  logic [31:0]   load_fmt;

  assign mem_op = mem_read_in | mem_write_in;

  // Stores only know B/H/W; anything else is a word. Loads also accept BU/HU.
  always_comb begin
    acc_nxt       = '0;
    acc_nxt.addr  = alu_result_in;
    acc_nxt.we    = mem_write_in;
    acc_nxt.uns   = funct3_in[2];
    if (mem_write_in)
      acc_nxt.sz = (funct3_in == 3'b000) ? SZ_B : (funct3_in == 3'b001) ? SZ_H : SZ_W;
    else
      acc_nxt.sz = (funct3_in[1:0] == 2'b00) ? SZ_B : (funct3_in[1:0] == 2'b01) ? SZ_H : SZ_W;
    case (acc_nxt.sz)
      SZ_B: begin
        acc_nxt.be    = 4'b0001 << alu_result_in[1:0];
        acc_nxt.wdata = {4{write_data_in[7:0]}};
      end
      SZ_H: begin
        acc_nxt.be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
        acc_nxt.wdata = {2{write_data_in[15:0]}};
      end
      default: begin
        acc_nxt.be    = 4'b1111;
        acc_nxt.wdata = write_data_in;
      end
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (acc_nxt.sz == SZ_H)      misaligned = alu_result_in[0];
    else if (acc_nxt.sz == SZ_W) misaligned = |alu_result_in[1:0];
`endif
  end

  // Lane select on the raw word, then sign/zero extend.
  always_comb begin
    logic [31:0] sh;
    logic [15:0] half;
    sh   = dmem.dmem_rdata >> {acc.addr[1:0], 3'b000};
    half = acc.addr[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    case (acc.sz)
      SZ_B:    load_fmt = acc.uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_fmt = acc.uns ? {16'd0, half} : {{16{half[15]}}, half};
      default: load_fmt = dmem.dmem_rdata;
    endcase
  end

  assign timeout_hit = (WAIT_LIMIT != 0) && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      req_q    <= 1'b0;
      to_q     <= 1'b0;
      mis_q    <= 1'b0;
      data_q   <= '0;
      wait_cnt <= '0;
      acc      <= '0;
    end else begin
      case (state)
        S_IDLE: if (mem_op) begin
          acc      <= acc_nxt;
          wait_cnt <= '0;
          to_q     <= 1'b0;
          mis_q    <= 1'b0;
          if (misaligned) begin
            data_q <= '0;
            mis_q  <= 1'b1;
            state  <= S_DONE;
          end else begin
            req_q  <= 1'b1;
            state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem.dmem_ready) begin
            data_q <= acc.we ? 32'd0 : load_fmt;
            req_q  <= 1'b0;
            state  <= S_DONE;
          end else if (timeout_hit) begin
            data_q <= '0;
            to_q   <= 1'b1;
            req_q  <= 1'b0;
            state  <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        // Pipeline advances on this edge, so the same op is never seen twice.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_done    = (state == S_DONE);
  assign stall_core = ((state == S_IDLE) && mem_op) || (state == S_BUSY);

  assign stall_out      = rst & stall_core;
  assign RegWrite_out   = rst & RegWrite_in & ~stall_core & ~(in_done & (to_q | mis_q));
  assign timeout_out    = rst & in_done & to_q;
  assign MemtoReg_out   = MemtoReg_in;
  assign alu_result_out = alu_result_in;
  assign rd_out         = rd_in;
  assign read_data_out  = in_done ? data_q : 32'd0;
`ifdef MISALIGN_TRAP_EN
  assign misalign_out   = rst & in_done & mis_q;
`endif

  assign dmem.dmem_req   = rst & req_q;
  assign dmem.dmem_we    = acc.we;
  assign dmem.dmem_addr  = {acc.addr[ADDR_WIDTH-1:2], 2'b00};
  assign dmem.dmem_wdata = acc.wdata;
  assign dmem.dmem_be    = acc.be;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage load/store unit, directly upstream of the MEM/WB pipeline register; it feeds that register's RegWrite/MemtoReg/read_data/alu_result/rd inputs.
- Drives a data-memory request/ready handshake, generates store byte-enables, and formats load data (byte/halfword, signed/unsigned).
- Freezes the pipeline via stall_out while an access is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of alu_result_in and dmem_addr.
- WAIT_LIMIT, 0, maximum BUSY cycles without dmem_ready before abort; 0 = unlimited.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-low reset
- mem_read_in  input  1  load instruction in MEM
- mem_write_in  input  1  store instruction in MEM
- funct3_in  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_result_in  input  ADDR_WIDTH  effective address / ALU result
- write_data_in  input  32  store data (rs2)
- RegWrite_in, MemtoReg_in  input  1 each  control from EX/MEM
- rd_in  input  5  destination register
- RegWrite_out, MemtoReg_out  output  1 each  to MEM/WB
- read_data_out  output  32  formatted load data
- alu_result_out  output  ADDR_WIDTH  pass-through of alu_result_in
- rd_out  output  5  pass-through of rd_in
- stall_out  output  1  freeze PC/IF/ID/EX/MEM registers
- timeout_out  output  1  one-cycle pulse on WAIT_LIMIT abort
- dmem_req  output  1  memory request, registered
- dmem_we  output  1  1 = write
- dmem_addr  output  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2], 2'b00})
- dmem_wdata  output  32  lane-replicated store data
- dmem_be  output  4  byte enables
- dmem_ready  input  1  access complete; dmem_rdata valid this cycle
- dmem_rdata  input  32  raw read word

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset (rst low at a clk edge) → IDLE, dmem_req=0, data register=0, wait counter=0.
- While rst is low, stall_out, RegWrite_out, dmem_req and timeout_out read 0 combinationally.
- IDLE, no memory op: pass-through. Outputs equal their inputs, read_data_out=0, stall_out=0.
- IDLE, memory op: capture address, data, size and we. Next state BUSY. stall_out=1 combinationally in this same cycle.
- BUSY: dmem_req=1; addr/we/wdata/be held stable. stall_out=1.
  - dmem_ready=1: latch formatted load data (0 for stores), go to DONE.
- DONE: stall_out=0, dmem_req=0, read_data_out = latched data, then IDLE. The pipeline advances on this edge, so the op is not retriggered.
- Minimum op latency is 3 cycles: IDLE, BUSY with ready, DONE.
- RegWrite_out is forced 0 whenever stall_out=1, so MEM/WB captures bubbles.
- MemtoReg_out, alu_result_out and rd_out are always pass-through.
- mem_read_in and mem_write_in both high: treated as a store.
- Store byte-enables and data:
  - SB: be = 4'b0001 << addr[1:0], wdata = byte replicated ×4.
  - SH: be = addr[1] ? 1100 : 0011, wdata = half replicated ×2.
  - SW: be = 1111.
  - Other funct3 values: treated as SW.
- Load formatting:
  - B/BU: byte lane addr[1:0], sign- or zero-extended.
  - H/HU: half lane addr[1], sign- or zero-extended.
  - W and other funct3 values: full word.
- WAIT_LIMIT>0: counter runs in BUSY and clears on entry.
  - Reaching WAIT_LIMIT without ready: go to DONE with data 0, timeout_out=1 and RegWrite_out=0 in DONE.
  - dmem_req drops at that edge.
- dmem_ready outside BUSY is ignored.
- Reset mid-BUSY abandons the access; no DONE cycle occurs.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Adds output misalign_out (1 bit, reset 0).
  - Misaligned cases: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0.
  - Misaligned access goes IDLE→DONE directly, with no dmem_req and one stall cycle.
  - In DONE: misalign_out=1, RegWrite_out=0, read_data_out=0.
- Not defined: no misalign_out port. Low address bits beyond the access size are ignored, so accesses are forced aligned.

Test Plan:
- LW addr 0x100, dmem_ready on first BUSY cycle, rdata 0xDEADBEEF → dmem_req 1 cycle, stall 2 cycles, DONE read_data_out=0xDEADBEEF, RegWrite_out=1.
- LB addr 0x103, rdata 0x80FF_0000 → read_data_out=0xFFFFFF80; LBU same → 0x00000080; LHU addr 0x102 → 0x000080FF.
- SB addr 0x101, write_data 0x12345678 → dmem_be=0010, dmem_wdata=0x78787878, dmem_we=1; SH addr 0x102 → be=1100, wdata=0x56785678.
- dmem_ready held low 5 cycles then high → dmem_req/addr stable all 6 BUSY cycles, stall_out high, RegWrite_out 0 throughout; WAIT_LIMIT=3 variant → timeout_out pulse after 3 BUSY cycles, read_data_out=0.
- rst low during BUSY → next edge IDLE, dmem_req=0, stall_out=0; subsequent LW completes normally.
- With MISALIGN_TRAP_EN, LW addr 0x102 → no dmem_req, one stall cycle, misalign_out=1, RegWrite_out=0.
